conv_window_gen: RTL

//  Streaming 3x3 sliding-window generator that sits directly upstream of the conv array.
//  - Consumes one signed 8-bit pixel per accepted beat, in raster order, for one channel
//    of a pre-padded frame (IMG_H x IMG_W).
//  - Uses two line buffers plus a 3x3 register window to emit every valid (stride 1,
//    no further padding) 3x3 window with its output coordinate.
//  - Windows drive w_0..w_8 of the conv MAC units.
//  - Default 418x418 input yields the 416x416 output map.

---
 rtl/conv_window_gen.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/conv_window_gen.sv
// -----------------------------------------------------------------------------
// conv_window_gen
//   Streaming 3x3 sliding-window generator. It takes one signed pixel per
//   accepted beat, in raster order, from a pre-padded IMG_H x IMG_W frame. For
//   every valid stride-1 position it emits the 3x3 window and the window's
//   output coordinate.
//
//   Two line buffers hold the previous two rows. A two-column shift register
//   holds the left and middle window columns. The right column is assembled
//   from the line-buffer reads plus the incoming pixel.
//
// Ports
//   clk_i          clock, rising edge
//   rst_n          asynchronous active-low reset
//   flush_i        synchronous frame abort (drops the input beat and held window)
//   s_valid_i      input pixel valid
//   s_ready_o      block can accept a pixel this cycle
//   s_data_i       input pixel (signed, passed through bit-exact)
//   m_valid_o      window valid
//   m_ready_i      consumer accepts window
//   w_0_o..w_8_o   window taps, w_0 = (r-2,c-2) ... w_8 = (r,c)
//   m_row_o        output row of the window (r-2)
//   m_col_o        output col of the window (c-2)
//   m_last_o       window is the last one of the frame
//   frame_done_o   one-cycle pulse after the last window is accepted
// -----------------------------------------------------------------------------
module conv_window_gen #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 418,
  parameter int IMG_H  = 418,
  parameter int CRD_W  = 9
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  input  logic [DATA_W-1:0] s_data_i,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [DATA_W-1:0] w_0_o,
  output logic [DATA_W-1:0] w_1_o,
  output logic [DATA_W-1:0] w_2_o,
  output logic [DATA_W-1:0] w_3_o,
  output logic [DATA_W-1:0] w_4_o,
  output logic [DATA_W-1:0] w_5_o,
  output logic [DATA_W-1:0] w_6_o,
  output logic [DATA_W-1:0] w_7_o,
  output logic [DATA_W-1:0] w_8_o,
  output logic [CRD_W-1:0]  m_row_o,
  output logic [CRD_W-1:0]  m_col_o,
  output logic              m_last_o,
  output logic              frame_done_o
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);

  logic [COL_W-1:0] in_col_q, in_col_d;
  logic [ROW_W-1:0] in_row_q, in_row_d;

  logic accept, load, col_end, row_end;
  logic m_valid_q, m_valid_d;
  logic frame_done_q, frame_done_d;
  logic m_last_q;
  logic [CRD_W-1:0] m_row_q, m_col_q;

  // Line buffers: lb1 holds row r-1, lb0 holds row r-2 (indexed by column).
  logic [DATA_W-1:0] lb0_mem [IMG_W];
  logic [DATA_W-1:0] lb1_mem [IMG_W];
  logic [DATA_W-1:0] lb0_rd, lb1_rd;

  // Window columns, index 0 = top row (r-2), index 2 = bottom row (r).
  logic [2:0][DATA_W-1:0] col_a_q, col_b_q, col_new;
  logic [8:0][DATA_W-1:0] taps, w_q;

  assign s_ready_o = !m_valid_q || m_ready_i;
  // A pixel offered in a flush cycle is dropped even when s_ready_o is high.
  assign accept    = s_valid_i && s_ready_o && !flush_i;
  assign col_end   = (in_col_q == COL_W'(IMG_W - 1));
  assign row_end   = (in_row_q == ROW_W'(IMG_H - 1));
  assign load      = accept && (in_row_q >= ROW_W'(2)) && (in_col_q >= COL_W'(2));

  // The read must see the current column in the same cycle that the pixel
  // arrives, because the window column is formed immediately.
  assign lb0_rd  = lb0_mem[in_col_q];
  assign lb1_rd  = lb1_mem[in_col_q];
  assign col_new = {s_data_i, lb1_rd, lb0_rd};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_taps
      assign taps[gi*3 + 0] = col_a_q[gi];
      assign taps[gi*3 + 1] = col_b_q[gi];
      assign taps[gi*3 + 2] = col_new[gi];
    end
  endgenerate

  always_comb begin
    in_col_d = in_col_q;
    in_row_d = in_row_q;
    if (accept) begin
      if (col_end) begin
        in_col_d = '0;
        in_row_d = row_end ? '0 : in_row_q + ROW_W'(1);
      end else begin
        in_col_d = in_col_q + COL_W'(1);
      end
    end
  end

  always_comb begin
    m_valid_d = m_valid_q;
    if (load)           m_valid_d = 1'b1;
    else if (m_ready_i) m_valid_d = 1'b0;
    frame_done_d = m_valid_q && m_ready_i && m_last_q;
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      in_col_q     <= '0;
      in_row_q     <= '0;
      m_valid_q    <= 1'b0;
      frame_done_q <= 1'b0;
      w_q          <= '0;
      m_row_q      <= '0;
      m_col_q      <= '0;
      m_last_q     <= 1'b0;
    end else if (flush_i) begin
      in_col_q     <= '0;
      in_row_q     <= '0;
      m_valid_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      in_col_q     <= in_col_d;
      in_row_q     <= in_row_d;
      m_valid_q    <= m_valid_d;
      frame_done_q <= frame_done_d;
      if (load) begin
        w_q      <= taps;
        m_row_q  <= CRD_W'(in_row_q - ROW_W'(2));
        m_col_q  <= CRD_W'(in_col_q - COL_W'(2));
        m_last_q <= row_end && col_end;
      end
    end
  end

  // Storage is not reset. Stale columns after a row wrap only feed windows at
  // columns 0/1, and those windows never emit.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      lb1_mem[in_col_q] <= s_data_i;
      lb0_mem[in_col_q] <= lb1_rd;
      col_a_q           <= col_b_q;
      col_b_q           <= col_new;
    end
  end

  assign m_valid_o    = m_valid_q;
  assign frame_done_o = frame_done_q;
  assign m_row_o      = m_row_q;
  assign m_col_o      = m_col_q;
  assign m_last_o     = m_last_q;
  assign w_0_o        = w_q[0];
  assign w_1_o        = w_q[1];
  assign w_2_o        = w_q[2];
  assign w_3_o        = w_q[3];
  assign w_4_o        = w_q[4];
  assign w_5_o        = w_q[5];
  assign w_6_o        = w_q[6];
  assign w_7_o        = w_q[7];
  assign w_8_o        = w_q[8];

endmodule
